regfile_sb: RTL and testbench

- Parametrised successor to the CPU's 16x16 register file in the ID stage.
- Generic width and depth; two read ports, one general write port, and a dedicated R0 side port used by multiply/divide for the high word or remainder.
- Adds same-cycle write-to-read bypass and a per-register pending scoreboard, so the hazard unit can stall on multi-cycle ops in flight.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 61 ++++++
 rtl/regfile_sb.sv | 83 ++++++++
 tb/tb_regfile_sb.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the ID-stage register file: reset image and the R0 side-port index.
package regfile_pkg;

   localparam int unsigned R0_IDX = 0;

   localparam logic [15:0] RF_INIT [16] = '{
      16'h0000, 16'h0F00, 16'h0050, 16'hFF0F,
      16'hF0FF, 16'h0040, 16'h0024, 16'h00FF,
      16'hAAAA, 16'h0000, 16'h0000, 16'h0000,
      16'hFFFF, 16'h0002, 16'h0000, 16'h0000
   };

   // Registers beyond the 16-entry legacy image reset to zero.
   function automatic logic [15:0] rf_init_val(input int unsigned idx);
      if (idx < 16) return RF_INIT[idx[3:0]];
      return '0;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for multi-cycle ops; set beats clear on the same edge.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_wa,
   input  logic              i_r0w,
   input  logic              i_set,
   input  logic [ADDR_W-1:0] i_set_addr,
   input  logic [ADDR_W-1:0] i_ra1,
   input  logic [ADDR_W-1:0] i_ra2,
   output logic              o_rd1_busy,
   output logic              o_rd2_busy,
   output logic              o_r0_busy,
   output logic              o_pend_err
);

   logic [DEPTH-1:0] r_pend;
   logic             r_err;
   logic [DEPTH-1:0] w_clr;
   logic [DEPTH-1:0] w_set;

   always_comb begin
      w_clr = '0;
      w_set = '0;
      if (i_we)  w_clr[i_wa]   = 1'b1;
      if (i_r0w) w_clr[R0_IDX] = 1'b1;
      if (i_set) w_set[i_set_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pend <= '0;
         r_err  <= 1'b0;
      end else begin
         r_pend <= (r_pend & ~w_clr) | w_set;
         if (i_set && r_pend[i_set_addr] && !w_clr[i_set_addr])
            r_err <= 1'b1;
      end
   end

   always_comb begin
      o_rd1_busy = r_pend[i_ra1];
      o_rd2_busy = r_pend[i_ra2];
      o_r0_busy  = r_pend[R0_IDX];
      if (BYPASS != 0) begin
         o_rd1_busy = r_pend[i_ra1]  & ~w_clr[i_ra1];
         o_rd2_busy = r_pend[i_ra2]  & ~w_clr[i_ra2];
         o_r0_busy  = r_pend[R0_IDX] & ~w_clr[R0_IDX];
      end
   end

   assign o_pend_err = r_err;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with R0 side port, write-to-read bypass and pending scoreboard.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] RA1,
   input  logic [ADDR_W-1:0] RA2,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   input  logic [ADDR_W-1:0] WA1,
   input  logic [DATA_W-1:0] WD1,
   input  logic              RegWrite,
   input  logic [DATA_W-1:0] R0D,
   input  logic              R0W,
   output logic [DATA_W-1:0] R0R,
   input  logic              set_pend,
   input  logic [ADDR_W-1:0] set_addr,
   output logic              RD1_busy,
   output logic              RD2_busy,
   output logic              R0_busy,
   output logic              pend_err
);

   localparam logic [ADDR_W-1:0] R0_A = ADDR_W'(R0_IDX);

   logic [DATA_W-1:0] r_regs [DEPTH];
   logic              w_byp;

   // R0D overrides WD1 on a shared R0 write because its assignment comes last.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            r_regs[i] <= DATA_W'(rf_init_val(i));
      end else begin
         if (RegWrite) r_regs[WA1]    <= WD1;
         if (R0W)      r_regs[R0_IDX] <= R0D;
      end
   end

   // Forwarding is suppressed in reset so outputs reflect the reset image.
   assign w_byp = (BYPASS != 0) && rst;

   always_comb begin
      RD1 = r_regs[RA1];
      RD2 = r_regs[RA2];
      R0R = r_regs[R0_IDX];
      if (w_byp) begin
         if (R0W && RA1 == R0_A)        RD1 = R0D;
         else if (RegWrite && RA1 == WA1) RD1 = WD1;
         if (R0W && RA2 == R0_A)        RD2 = R0D;
         else if (RegWrite && RA2 == WA1) RD2 = WD1;
         if (R0W)                         R0R = R0D;
         else if (RegWrite && WA1 == R0_A) R0R = WD1;
      end
   end

   regfile_scoreboard #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .i_we       (RegWrite),
      .i_wa       (WA1),
      .i_r0w      (R0W),
      .i_set      (set_pend),
      .i_set_addr (set_addr),
      .i_ra1      (RA1),
      .i_ra2      (RA2),
      .o_rd1_busy (RD1_busy),
      .o_rd2_busy (RD2_busy),
      .o_r0_busy  (R0_busy),
      .o_pend_err (pend_err)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed checks of regfile_sb: default build, BYPASS=0 build and a 32x32 build.
module tb_regfile_sb;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [3:0]  ra1, ra2, wa1, set_addr;
   logic [15:0] wd1, r0d;
   logic        regwrite, r0w, set_pend;

   logic [15:0] rd1, rd2, r0r;
   logic        rd1_busy, rd2_busy, r0_busy, pend_err;
   logic [15:0] nb_rd1, nb_rd2, nb_r0r;
   logic        nb_rd1_busy, nb_rd2_busy, nb_r0_busy, nb_pend_err;

   logic [4:0]  w_ra1, w_ra2, w_wa1, w_set_addr;
   logic [31:0] w_wd1, w_r0d, w_rd1, w_rd2, w_r0r;
   logic        w_regwrite, w_r0w, w_set_pend;
   logic        w_rd1_busy, w_rd2_busy, w_r0_busy, w_pend_err;

   int n_checks = 0;
   int n_errors = 0;

   regfile_sb dut (
      .clk(clk), .rst(rst), .RA1(ra1), .RA2(ra2), .RD1(rd1), .RD2(rd2),
      .WA1(wa1), .WD1(wd1), .RegWrite(regwrite), .R0D(r0d), .R0W(r0w), .R0R(r0r),
      .set_pend(set_pend), .set_addr(set_addr), .RD1_busy(rd1_busy),
      .RD2_busy(rd2_busy), .R0_busy(r0_busy), .pend_err(pend_err)
   );

   regfile_sb #(.BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .RA1(ra1), .RA2(ra2), .RD1(nb_rd1), .RD2(nb_rd2),
      .WA1(wa1), .WD1(wd1), .RegWrite(regwrite), .R0D(r0d), .R0W(r0w), .R0R(nb_r0r),
      .set_pend(set_pend), .set_addr(set_addr), .RD1_busy(nb_rd1_busy),
      .RD2_busy(nb_rd2_busy), .R0_busy(nb_r0_busy), .pend_err(nb_pend_err)
   );

   regfile_sb #(.DATA_W(32), .DEPTH(32)) dut_w (
      .clk(clk), .rst(rst), .RA1(w_ra1), .RA2(w_ra2), .RD1(w_rd1), .RD2(w_rd2),
      .WA1(w_wa1), .WD1(w_wd1), .RegWrite(w_regwrite), .R0D(w_r0d), .R0W(w_r0w),
      .R0R(w_r0r), .set_pend(w_set_pend), .set_addr(w_set_addr),
      .RD1_busy(w_rd1_busy), .RD2_busy(w_rd2_busy), .R0_busy(w_r0_busy),
      .pend_err(w_pend_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      regwrite = 1'b0; r0w = 1'b0; set_pend = 1'b0;
      w_regwrite = 1'b0; w_r0w = 1'b0; w_set_pend = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      ra1 = '0; ra2 = '0; wa1 = '0; set_addr = '0; wd1 = '0; r0d = '0;
      w_ra1 = '0; w_ra2 = '0; w_wa1 = '0; w_set_addr = '0; w_wd1 = '0; w_r0d = '0;
      idle();
      tick();

      // reset asserted mid-cycle with a write pending
      regwrite = 1'b1; wa1 = 4'd1; wd1 = 16'h1234;
      ra1 = 4'd1; ra2 = 4'd13; w_ra1 = 5'd1; w_ra2 = 5'd16;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_rd1", 32'(rd1), 32'h0F00);
      chk("rst_rd2", 32'(rd2), 32'h0002);
      tick();
      chk("rst_rd1_hold", 32'(rd1), 32'h0F00);
      chk("rst_busy", {29'd0, rd1_busy, rd2_busy, r0_busy}, 32'd0);
      chk("rst_err", 32'(pend_err), 32'd0);
      chk("w_rst_r1", w_rd1, 32'h0000_0F00);
      chk("w_rst_r16", w_rd2, 32'h0);
      chk("w_rst_busy", {28'd0, w_rd1_busy, w_rd2_busy, w_r0_busy, w_pend_err}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      idle();
      tick();

      // same-cycle bypass
      regwrite = 1'b1; wa1 = 4'd5; wd1 = 16'hBEEF; ra1 = 4'd5;
      #1;
      chk("byp_rd1", 32'(rd1), 32'hBEEF);
      chk("nobyp_rd1", 32'(nb_rd1), 32'h0040);
      tick();
      regwrite = 1'b0;
      #1;
      chk("byp_stored", 32'(rd1), 32'hBEEF);
      chk("nobyp_stored", 32'(nb_rd1), 32'hBEEF);

      // R0 side port beats general write to R0
      r0w = 1'b1; r0d = 16'h1111; regwrite = 1'b1; wa1 = 4'd0; wd1 = 16'h2222; ra1 = 4'd0;
      #1;
      chk("r0_r0r", 32'(r0r), 32'h1111);
      chk("r0_rd1", 32'(rd1), 32'h1111);
      chk("r0_nb_r0r", 32'(nb_r0r), 32'h0000);
      tick();
      idle();
      #1;
      chk("r0_stored", 32'(r0r), 32'h1111);
      chk("r0_nb_stored", 32'(nb_rd1), 32'h1111);

      // scoreboard set then bypassed clear
      set_pend = 1'b1; set_addr = 4'd3; ra2 = 4'd3;
      #1;
      chk("sb_pre", 32'(rd2_busy), 32'd0);
      tick();
      set_pend = 1'b0;
      #1;
      chk("sb_set", 32'(rd2_busy), 32'd1);
      chk("sb_nb_set", 32'(nb_rd2_busy), 32'd1);
      regwrite = 1'b1; wa1 = 4'd3; wd1 = 16'h3333;
      #1;
      chk("sb_clr_byp", 32'(rd2_busy), 32'd0);
      chk("sb_nb_clr", 32'(nb_rd2_busy), 32'd1);
      tick();
      regwrite = 1'b0;
      #1;
      chk("sb_cleared", 32'(rd2_busy), 32'd0);
      chk("sb_nb_cleared", 32'(nb_rd2_busy), 32'd0);

      // R0 busy via side-port clear
      set_pend = 1'b1; set_addr = 4'd0;
      tick();
      set_pend = 1'b0;
      #1;
      chk("r0_busy_set", 32'(r0_busy), 32'd1);
      r0w = 1'b1; r0d = 16'h0099;
      #1;
      chk("r0_busy_byp", 32'(r0_busy), 32'd0);
      chk("r0_nb_busy", 32'(nb_r0_busy), 32'd1);
      tick();
      r0w = 1'b0;
      #1;
      chk("r0_busy_clr", 32'(r0_busy), 32'd0);

      // set/clear collision, then re-issue while pending
      set_pend = 1'b1; set_addr = 4'd7; regwrite = 1'b1; wa1 = 4'd7; wd1 = 16'h7777; ra1 = 4'd7;
      tick();
      idle();
      #1;
      chk("col_busy", 32'(rd1_busy), 32'd1);
      chk("col_err", 32'(pend_err), 32'd0);
      set_pend = 1'b1; regwrite = 1'b1;
      tick();
      idle();
      #1;
      chk("col2_busy", 32'(rd1_busy), 32'd1);
      chk("col2_err", 32'(pend_err), 32'd0);
      set_pend = 1'b1;
      tick();
      set_pend = 1'b0;
      #1;
      chk("dup_err", 32'(pend_err), 32'd1);
      chk("dup_busy", 32'(rd1_busy), 32'd1);
      tick(); tick();
      chk("err_sticky", 32'(pend_err), 32'd1);

      // wide build write/readback
      w_regwrite = 1'b1; w_wa1 = 5'd31; w_wd1 = 32'hDEAD_BEEF;
      tick();
      w_wa1 = 5'd16; w_wd1 = 32'h1234_5678;
      tick();
      w_regwrite = 1'b0; w_ra1 = 5'd31; w_ra2 = 5'd16;
      #1;
      chk("w_r31", w_rd1, 32'hDEAD_BEEF);
      chk("w_r16", w_rd2, 32'h1234_5678);

      // reset clears scoreboard and restores the image
      @(negedge clk);
      rst = 1'b0;
      #1;
      ra1 = 4'd5;
      #1;
      chk("rst2_err", 32'(pend_err), 32'd0);
      chk("rst2_rd1", 32'(rd1), 32'h0040);
      chk("rst2_r0r", 32'(r0r), 32'h0000);
      ra1 = 4'd7;
      #1;
      chk("rst2_busy", 32'(rd1_busy), 32'd0);
      chk("w_rst2_r31", w_rd1, 32'h0);
      rst = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
